// File: rtl/div_sequencer_if.sv
// Handshake bundle between the E-stage sequencing logic and the iterative divider.
interface div_sequencer_if #(parameter int XLEN = 64) ();
  logic            StartE;
  logic [5:0]      ALUControlE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            StallDivE;
  logic            DivDoneE;
  logic [XLEN-1:0] DivResultE;

  modport master (
    output StartE, ALUControlE, SrcAE, SrcBE, FlushE,
    input  StallDivE, DivDoneE, DivResultE
  );

  modport slave (
    input  StartE, ALUControlE, SrcAE, SrcBE, FlushE,
    output StallDivE, DivDoneE, DivResultE
  );
endinterface

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for RV64M div/divu/rem/remu and their W forms.
// Stalls the front of the pipe while iterating and presents one result for the ALU mux.
module div_sequencer #(
  parameter int XLEN = 64
) (
  input  logic           clk,
  input  logic           reset,
  div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t          state_r, state_n;
  logic [6:0]      cnt_r;
  logic [XLEN-1:0] rem_r, quo_r, dvs_r, result_r;
  logic            negq_r, negr_r, is_rem_r, is_w_r;

  logic            op_w_s, op_signed_s, op_rem_s;
  logic [4:0]      op_base_s;
  logic [XLEN-1:0] a_ext_s, b_ext_s, a_mag_s, b_mag_s, min_s;
  logic [XLEN-1:0] special_raw_s, special_res_s, quo_init_s;
  logic            sa_s, sb_s, div_zero_s, ovf_s;
  logic [XLEN:0]   rem_sh_s;
  logic [XLEN-1:0] rem_nxt_s, quo_nxt_s;
  logic [XLEN-1:0] quo_fix_s, rem_fix_s, fix_raw_s, fix_res_s;
  logic            stall_s, done_s;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  assign op_w_s      = bus.ALUControlE[5];
  assign op_base_s   = bus.ALUControlE[4:0];
  assign op_signed_s = (op_base_s == 5'd6) || (op_base_s == 5'd8);
  assign op_rem_s    = (op_base_s == 5'd8) || (op_base_s == 5'd9);

  // Operand extension, magnitudes and special-case detection at op width
  always_comb begin
    a_ext_s = bus.SrcAE;
    b_ext_s = bus.SrcBE;
    if (op_w_s) begin
      if (op_signed_s) begin
        a_ext_s = sext32(bus.SrcAE[31:0]);
        b_ext_s = sext32(bus.SrcBE[31:0]);
      end else begin
        a_ext_s = {{(XLEN-32){1'b0}}, bus.SrcAE[31:0]};
        b_ext_s = {{(XLEN-32){1'b0}}, bus.SrcBE[31:0]};
      end
    end else begin
      a_ext_s = bus.SrcAE;
      b_ext_s = bus.SrcBE;
    end
    sa_s       = op_signed_s & a_ext_s[XLEN-1];
    sb_s       = op_signed_s & b_ext_s[XLEN-1];
    a_mag_s    = sa_s ? ({XLEN{1'b0}} - a_ext_s) : a_ext_s;
    b_mag_s    = sb_s ? ({XLEN{1'b0}} - b_ext_s) : b_ext_s;
    min_s      = op_w_s ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero_s = (b_ext_s == {XLEN{1'b0}});
    ovf_s      = op_signed_s && (a_ext_s == min_s) && (b_ext_s == {XLEN{1'b1}});
    if (div_zero_s) begin
      special_raw_s = op_rem_s ? a_ext_s : {XLEN{1'b1}};
    end else begin
      special_raw_s = op_rem_s ? {XLEN{1'b0}} : a_ext_s;
    end
    special_res_s = op_w_s ? sext32(special_raw_s[31:0]) : special_raw_s;
    // W dividends sit in the upper half so 32 shifts consume exactly their bits
    quo_init_s = op_w_s ? (a_mag_s << 7'd32) : a_mag_s;
  end

  // One restoring step plus the sign/width fix-up of the finished quotient/remainder
  always_comb begin
    rem_sh_s = {rem_r, quo_r[XLEN-1]};
    if (rem_sh_s >= {1'b0, dvs_r}) begin
      rem_nxt_s = rem_sh_s[XLEN-1:0] - dvs_r;
      quo_nxt_s = {quo_r[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt_s = rem_sh_s[XLEN-1:0];
      quo_nxt_s = {quo_r[XLEN-2:0], 1'b0};
    end
    quo_fix_s = negq_r ? ({XLEN{1'b0}} - quo_r) : quo_r;
    rem_fix_s = negr_r ? ({XLEN{1'b0}} - rem_r) : rem_r;
    fix_raw_s = is_rem_r ? rem_fix_s : quo_fix_s;
    fix_res_s = is_w_r ? sext32(fix_raw_s[31:0]) : fix_raw_s;
  end

  // Next-state and handshake outputs; flush always wins
  always_comb begin
    state_n = state_r;
    stall_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.StartE && !bus.FlushE) begin
          stall_s = 1'b1;
          state_n = (div_zero_s || ovf_s) ? DONE : CALC;
        end else begin
          state_n = IDLE;
        end
      end
      CALC: begin
        if (bus.FlushE) begin
          state_n = IDLE;
        end else begin
          stall_s = 1'b1;
          state_n = (cnt_r == 7'd1) ? FIXUP : CALC;
        end
      end
      FIXUP: begin
        if (bus.FlushE) begin
          state_n = IDLE;
        end else begin
          stall_s = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        if (bus.FlushE) begin
          done_s = 1'b0;
        end else begin
          done_s = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Operand capture, iteration registers and the held result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= 7'd0;
      rem_r    <= {XLEN{1'b0}};
      quo_r    <= {XLEN{1'b0}};
      dvs_r    <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
      negq_r   <= 1'b0;
      negr_r   <= 1'b0;
      is_rem_r <= 1'b0;
      is_w_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.StartE && !bus.FlushE) begin
            dvs_r    <= b_mag_s;
            quo_r    <= quo_init_s;
            rem_r    <= {XLEN{1'b0}};
            cnt_r    <= op_w_s ? 7'd32 : 7'(XLEN);
            negq_r   <= sa_s ^ sb_s;
            negr_r   <= sa_s;
            is_rem_r <= op_rem_s;
            is_w_r   <= op_w_s;
            if (div_zero_s || ovf_s) begin
              result_r <= special_res_s;
            end
          end
        end
        CALC: begin
          if (!bus.FlushE) begin
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
            cnt_r <= cnt_r - 7'd1;
          end
        end
        FIXUP: begin
          if (!bus.FlushE) begin
            result_r <= fix_res_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.StallDivE  = stall_s;
  assign bus.DivDoneE   = done_s;
  assign bus.DivResultE = result_r;

endmodule
